debounce_timer_arbiter: RTL and testbench
=========================================

Name: debounce_timer_arbiter

Overview:
- Multi-channel chatter filter.
- N raw switch inputs share one countdown timer instead of one timer per channel.
- A round-robin arbiter grants the timer to one channel whose raw input disagrees with its filtered output. The channel's output changes only after the input has held the new level for the full hold time.
- Sits between the board switch/button pins and downstream control logic.

Parameters:
- N, 4, number of input channels (2..16)
- HOLD, 15, number of decrement cycles the input must stay stable after the grant cycle
- CNT_W, 4, timer width; must satisfy HOLD < 2**CNT_W
- RST_VAL, 0, reset level of every filtered output bit
- ID_W, 2, owner index width; must satisfy N <= 2**ID_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in  in  N  raw inputs; already synchronised to clk upstream
- out  out  N  filtered levels, registered
- chg  out  N  one-cycle pulse on bit i in the cycle after out[i] changes (registered)
- busy  out  1  1 while the timer is owned (state COUNT)
- owner  out  ID_W  index of the current timer owner; holds the last owner when idle

Behaviour:
- Reset (rst=1 at an edge):
  - out all RST_VAL, chg 0, busy 0, owner 0
  - round-robin pointer 0, timer 0, state IDLE
  - Applies mid-COUNT too: the count in progress is discarded and no commit happens.
- Request: req[i] = in[i] XOR out[i], combinational, not latched. A bounce that ends before a channel is granted leaves no trace.
- FSM states: IDLE, COUNT.
- IDLE:
  - If req is nonzero, grant the first set bit searching from the pointer upward, wrapping modulo N.
  - Grant action: owner <= that index, timer <= HOLD, state <= COUNT.
  - If req is zero, remain in IDLE.
- COUNT, evaluated each edge on channel o = owner:
  - req[o]=0 (input bounced back): abort. State <= IDLE, pointer <= o+1 mod N, out unchanged, no chg pulse.
  - req[o]=1 and timer != 0: timer <= timer-1.
  - req[o]=1 and timer == 0: commit. out[o] <= in[o], chg[o] pulses next cycle, state <= IDLE, pointer <= o+1 mod N.
- Latency: grant at edge e0, commit at edge e(HOLD+1). The input must be sampled stable on HOLD+2 consecutive edges. With HOLD=15, out changes 16 edges after the grant edge.
- No back-to-back grant: after a commit or abort there is always one IDLE cycle. Re-arbitration happens at the following edge.
- Non-owner inputs are ignored during COUNT. They are re-evaluated at the next IDLE edge.
- Fairness: the pointer advances past the last owner. Any continuously mismatching channel is granted within (N-1)*(HOLD+3) cycles.
- Simultaneous mismatches in IDLE: only one grant, per the round-robin order. All other channels wait.
- HOLD=0 is legal: commit on the edge after the grant.
- chg is zero except for exactly one bit, for one cycle, per commit.
- Timer decrement must never wrap; it stops at 0 by construction.

Test Plan:
- Reset: hold rst 3 cycles with in=4'b1111 -> out=0, chg=0, busy=0, owner=0. On the first post-reset edge busy rises and owner=0.
- Clean press, N=4, HOLD=15: in[2] 0->1 and held -> busy=1, owner=2 at grant edge e0. out[2]=1 after e16. chg=4'b0100 for exactly one cycle after that. busy=0 after e16.
- Chatter abort: in[1] rises, stays 5 cycles, drops for 1 cycle, then rises again -> no chg. Abort returns to IDLE. A fresh grant follows and out[1]=1 only 16 edges after the re-grant.
- Contention: in[0] and in[3] rise on the same edge with pointer=0 -> channel 0 granted first and commits. After one IDLE cycle channel 3 is granted and commits 16 edges later. out ends 4'b1001.
- Round-robin fairness: all four inputs toggle continuously stable -> grant order 0,1,2,3,0. No channel is skipped.
- Reset mid-count: rst asserted at timer=7 while owner=1 with in[1]=1 -> out[1] stays 0, no chg, busy=0 next cycle. The re-grant after reset releases restarts the timer at 15.

Source files
------------

// File: rtl/debounce_timer_arbiter.sv
// Multi-channel switch debouncer: N raw inputs share one hold timer, which a
// round-robin arbiter grants to one channel whose input disagrees with its output.
module debounce_timer_arbiter #(
  parameter int   N       = 4,
  parameter int   HOLD    = 15,
  parameter int   CNT_W   = 4,
  parameter logic RST_VAL = 1'b0,
  parameter int   ID_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in,
  output logic [N-1:0]    out,
  output logic [N-1:0]    chg,
  output logic            busy,
  output logic [ID_W-1:0] owner
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [CNT_W-1:0]  r_timer;
  logic [N-1:0]      r_out;
  logic [N-1:0]      r_chg;
  logic              r_busy;

  logic [N-1:0]      w_req;
  logic              w_any;
  logic              w_own_req;
  logic [ID_W-1:0]   w_pick;
  logic [ID_W-1:0]   w_next_ptr;

  // First requesting channel at or above ptr, wrapping modulo N.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  assign w_req      = in ^ r_out;
  assign w_any      = |w_req;
  assign w_own_req  = w_req[r_owner];
  assign w_pick     = rr_pick(w_req, r_ptr);
  assign w_next_ptr = (r_owner == ID_W'(N - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_timer <= '0;
      r_out   <= {N{RST_VAL}};
      r_chg   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_chg <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_timer <= CNT_W'(HOLD);
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
          end
        end
        S_COUNT: begin
          // Owner bounced back before the hold time expired: drop it, no commit.
          if (!w_own_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end else if (r_timer != '0) begin
            r_timer <= dec_sat(r_timer);
          end else begin
            r_out[r_owner] <= in[r_owner];
            r_chg[r_owner] <= 1'b1;
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_ptr          <= w_next_ptr;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign chg   = r_chg;
  assign busy  = r_busy;
  assign owner = r_owner;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed bench for debounce_timer_arbiter (N=4, HOLD=15): reset, clean press,
// chatter abort, contention, round-robin order and reset during a count.
module tb_debounce_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tin = 4'b0000;
  logic [3:0] tout;
  logic [3:0] tchg;
  logic       tbusy;
  logic [1:0] towner;

  int total = 0;
  int bad   = 0;

  debounce_timer_arbiter #(
    .N(4), .HOLD(15), .CNT_W(4), .RST_VAL(1'b0), .ID_W(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (tin),
    .out  (tout),
    .chg  (tchg),
    .busy (tbusy),
    .owner(towner)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    rst = 1'b1;
    tin = v;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held three cycles with all inputs high
    rst = 1'b1;
    tin = 4'b1111;
    tick(3);
    chk("rst_out",   32'(tout),   32'h0);
    chk("rst_chg",   32'(tchg),   32'h0);
    chk("rst_busy",  32'(tbusy),  32'h0);
    chk("rst_owner", 32'(towner), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_busy",  32'(tbusy),  32'h1);
    chk("post_rst_owner", 32'(towner), 32'h0);
    tin = 4'b0000;
    tick(1);
    chk("post_rst_abort_busy", 32'(tbusy), 32'h0);
    chk("post_rst_abort_chg",  32'(tchg),  32'h0);

    // Clean press on channel 2
    do_reset(4'b0000);
    tin = 4'b0100;
    tick(1);
    chk("press_grant_busy",  32'(tbusy),  32'h1);
    chk("press_grant_owner", 32'(towner), 32'h2);
    tick(15);
    chk("press_e15_out",  32'(tout),  32'h0);
    chk("press_e15_busy", 32'(tbusy), 32'h1);
    tick(1);
    chk("press_e16_out",  32'(tout),  32'h4);
    chk("press_e16_chg",  32'(tchg),  32'h4);
    chk("press_e16_busy", 32'(tbusy), 32'h0);
    tick(1);
    chk("press_e17_chg",  32'(tchg),  32'h0);
    chk("press_e17_out",  32'(tout),  32'h4);
    chk("press_e17_busy", 32'(tbusy), 32'h0);

    // Chatter on channel 1: abort, then fresh grant
    do_reset(4'b0000);
    tin = 4'b0010;
    tick(1);
    chk("chat_grant_owner", 32'(towner), 32'h1);
    tick(4);
    tin = 4'b0000;
    tick(1);
    chk("chat_abort_busy", 32'(tbusy), 32'h0);
    chk("chat_abort_chg",  32'(tchg),  32'h0);
    chk("chat_abort_out",  32'(tout),  32'h0);
    tin = 4'b0010;
    tick(1);
    chk("chat_regrant_busy",  32'(tbusy),  32'h1);
    chk("chat_regrant_owner", 32'(towner), 32'h1);
    chk("chat_regrant_chg",   32'(tchg),   32'h0);
    tick(15);
    chk("chat_e15_out", 32'(tout), 32'h0);
    tick(1);
    chk("chat_e16_out", 32'(tout), 32'h2);
    chk("chat_e16_chg", 32'(tchg), 32'h2);

    // Channels 0 and 3 rise together with pointer at 0
    do_reset(4'b0000);
    tin = 4'b1001;
    tick(1);
    chk("cont_g0_owner", 32'(towner), 32'h0);
    tick(16);
    chk("cont_c0_out",  32'(tout),  32'h1);
    chk("cont_c0_chg",  32'(tchg),  32'h1);
    chk("cont_c0_busy", 32'(tbusy), 32'h0);
    tick(1);
    chk("cont_g3_busy",  32'(tbusy),  32'h1);
    chk("cont_g3_owner", 32'(towner), 32'h3);
    tick(16);
    chk("cont_c3_out", 32'(tout), 32'h9);
    chk("cont_c3_chg", 32'(tchg), 32'h8);

    // All four channels mismatching: grant order 0,1,2,3 then back to 0
    do_reset(4'b0000);
    tin = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk($sformatf("rr_grant%0d_owner", i), 32'(towner), 32'(i));
      chk($sformatf("rr_grant%0d_busy", i),  32'(tbusy),  32'h1);
      tick(16);
      chk($sformatf("rr_commit%0d_chg", i),  32'(tchg),   32'(1 << i));
    end
    chk("rr_final_out", 32'(tout), 32'hf);
    tin = 4'b0000;
    tick(1);
    chk("rr_wrap_owner", 32'(towner), 32'h0);
    chk("rr_wrap_busy",  32'(tbusy),  32'h1);

    // Reset while channel 1 is mid-count (timer at 7)
    do_reset(4'b0000);
    tin = 4'b0010;
    tick(1);
    chk("midrst_grant_owner", 32'(towner), 32'h1);
    tick(8);
    rst = 1'b1;
    tick(1);
    chk("midrst_busy",  32'(tbusy),  32'h0);
    chk("midrst_out",   32'(tout),   32'h0);
    chk("midrst_chg",   32'(tchg),   32'h0);
    chk("midrst_owner", 32'(towner), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("midrst_regrant_owner", 32'(towner), 32'h1);
    chk("midrst_regrant_busy",  32'(tbusy),  32'h1);
    tick(15);
    chk("midrst_e15_out",  32'(tout),  32'h0);
    chk("midrst_e15_busy", 32'(tbusy), 32'h1);
    tick(1);
    chk("midrst_e16_out", 32'(tout), 32'h2);
    chk("midrst_e16_chg", 32'(tchg), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
